// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use stall, write bypass and
//            EX/MEM + MEM/WB operand forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_in,
    output logic        id_ready_out,
    input  logic [4:0]  id_rs1_in,
    input  logic [4:0]  id_rs2_in,
    input  logic [4:0]  id_rd_in,
    input  logic [63:0] id_rs1_data_in,
    input  logic [63:0] id_rs2_data_in,
    input  logic [63:0] id_imm_in,
    input  logic        id_use_imm_in,
    input  logic [3:0]  id_alu_op_in,
    input  logic        id_reg_write_in,
    input  logic        id_mem_read_in,
    input  logic        flush_in,
    output logic        ex_valid_out,
    input  logic        ex_ready_in,
    output logic [63:0] ex_operand1_out,
    output logic [63:0] ex_operand2_out,
    output logic [3:0]  ex_alu_op_out,
    output logic [4:0]  ex_rd_out,
    output logic        ex_reg_write_out,
    output logic        ex_mem_read_out,
    input  logic [4:0]  mem_rd_in,
    input  logic        mem_reg_write_in,
    input  logic [63:0] mem_result_in,
    input  logic [4:0]  wb_rd_in,
    input  logic        wb_reg_write_in,
    input  logic [63:0] wb_result_in
);

    localparam logic [4:0] c_ZERO_REG = 5'd0;

    logic        r_valid;
    logic        r_rst_done;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [63:0] r_rs1_data;
    logic [63:0] r_rs2_data;
    logic [63:0] r_imm;
    logic        r_use_imm;
    logic [3:0]  r_alu_op;
    logic        r_reg_write;
    logic        r_mem_read;

    logic        w_load_use;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic [63:0] w_cap_rs1_data;
    logic [63:0] w_cap_rs2_data;
    logic        w_wb_hit_rs1;
    logic        w_wb_hit_rs2;
    logic [63:0] w_fwd_rs1;
    logic [63:0] w_fwd_rs2;

    assign w_load_use = r_valid && r_mem_read && (r_rd != c_ZERO_REG) && id_valid_in &&
                        ((id_rs1_in == r_rd) || (!id_use_imm_in && (id_rs2_in == r_rd)));

    // r_rst_done keeps the first edge after reset release from accepting anything.
    assign id_ready_out = (!r_valid || ex_ready_in) && !w_load_use && !flush_in && r_rst_done;
    assign w_in_xfer    = id_valid_in && id_ready_out;
    assign w_out_xfer   = r_valid && ex_ready_in;

    // Register file writes in the same cycle as the read are bypassed at capture.
    assign w_cap_rs1_data = (wb_reg_write_in && (wb_rd_in == id_rs1_in) && (id_rs1_in != c_ZERO_REG))
                            ? wb_result_in : id_rs1_data_in;
    assign w_cap_rs2_data = (wb_reg_write_in && (wb_rd_in == id_rs2_in) && (id_rs2_in != c_ZERO_REG))
                            ? wb_result_in : id_rs2_data_in;

    assign w_wb_hit_rs1 = wb_reg_write_in && (wb_rd_in == r_rs1) && (r_rs1 != c_ZERO_REG);
    assign w_wb_hit_rs2 = wb_reg_write_in && (wb_rd_in == r_rs2) && (r_rs2 != c_ZERO_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rst_done  <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_alu_op    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (flush_in) begin
                r_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_valid     <= 1'b1;
                r_rs1       <= id_rs1_in;
                r_rs2       <= id_rs2_in;
                r_rd        <= id_rd_in;
                r_rs1_data  <= w_cap_rs1_data;
                r_rs2_data  <= w_cap_rs2_data;
                r_imm       <= id_imm_in;
                r_use_imm   <= id_use_imm_in;
                r_alu_op    <= id_alu_op_in;
                r_reg_write <= id_reg_write_in;
                r_mem_read  <= id_mem_read_in;
            end else begin
                if (w_out_xfer) begin
                    r_valid <= 1'b0;
                end
                // A stalled instruction must not lose a write that retires while it waits.
                if (r_valid && w_wb_hit_rs1) begin
                    r_rs1_data <= wb_result_in;
                end
                if (r_valid && w_wb_hit_rs2) begin
                    r_rs2_data <= wb_result_in;
                end
            end
        end
    end

    generate
        if (FWD_EN) begin : g_fwd
            always_comb begin
                w_fwd_rs1 = r_rs1_data;
                if (mem_reg_write_in && (mem_rd_in == r_rs1) && (r_rs1 != c_ZERO_REG)) begin
                    w_fwd_rs1 = mem_result_in;
                end else if (w_wb_hit_rs1) begin
                    w_fwd_rs1 = wb_result_in;
                end
            end
            always_comb begin
                w_fwd_rs2 = r_rs2_data;
                if (mem_reg_write_in && (mem_rd_in == r_rs2) && (r_rs2 != c_ZERO_REG)) begin
                    w_fwd_rs2 = mem_result_in;
                end else if (w_wb_hit_rs2) begin
                    w_fwd_rs2 = wb_result_in;
                end
            end
        end else begin : g_no_fwd
            assign w_fwd_rs1 = r_rs1_data;
            assign w_fwd_rs2 = r_rs2_data;
        end
    endgenerate

    assign ex_valid_out     = r_valid;
    assign ex_operand1_out  = w_fwd_rs1;
    assign ex_operand2_out  = r_use_imm ? r_imm : w_fwd_rs2;
    assign ex_alu_op_out    = r_alu_op;
    assign ex_rd_out        = r_rd;
    assign ex_reg_write_out = r_reg_write;
    assign ex_mem_read_out  = r_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage (FWD_EN=1 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid_in;
    logic [4:0]  id_rs1_in, id_rs2_in, id_rd_in;
    logic [63:0] id_rs1_data_in, id_rs2_data_in, id_imm_in;
    logic        id_use_imm_in;
    logic [3:0]  id_alu_op_in;
    logic        id_reg_write_in, id_mem_read_in;
    logic        flush_in;
    logic        ex_ready_in;
    logic [4:0]  mem_rd_in, wb_rd_in;
    logic        mem_reg_write_in, wb_reg_write_in;
    logic [63:0] mem_result_in, wb_result_in;

    logic        id_ready_out, ex_valid_out, ex_reg_write_out, ex_mem_read_out;
    logic [63:0] ex_operand1_out, ex_operand2_out;
    logic [3:0]  ex_alu_op_out;
    logic [4:0]  ex_rd_out;

    logic        nf_id_ready_out, nf_ex_valid_out, nf_ex_reg_write_out, nf_ex_mem_read_out;
    logic [63:0] nf_ex_operand1_out, nf_ex_operand2_out;
    logic [3:0]  nf_ex_alu_op_out;
    logic [4:0]  nf_ex_rd_out;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_in(id_valid_in), .id_ready_out(id_ready_out),
        .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in), .id_rd_in(id_rd_in),
        .id_rs1_data_in(id_rs1_data_in), .id_rs2_data_in(id_rs2_data_in),
        .id_imm_in(id_imm_in), .id_use_imm_in(id_use_imm_in), .id_alu_op_in(id_alu_op_in),
        .id_reg_write_in(id_reg_write_in), .id_mem_read_in(id_mem_read_in),
        .flush_in(flush_in),
        .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in),
        .ex_operand1_out(ex_operand1_out), .ex_operand2_out(ex_operand2_out),
        .ex_alu_op_out(ex_alu_op_out), .ex_rd_out(ex_rd_out),
        .ex_reg_write_out(ex_reg_write_out), .ex_mem_read_out(ex_mem_read_out),
        .mem_rd_in(mem_rd_in), .mem_reg_write_in(mem_reg_write_in), .mem_result_in(mem_result_in),
        .wb_rd_in(wb_rd_in), .wb_reg_write_in(wb_reg_write_in), .wb_result_in(wb_result_in)
    );

    id_ex_stage #(.FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n),
        .id_valid_in(id_valid_in), .id_ready_out(nf_id_ready_out),
        .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in), .id_rd_in(id_rd_in),
        .id_rs1_data_in(id_rs1_data_in), .id_rs2_data_in(id_rs2_data_in),
        .id_imm_in(id_imm_in), .id_use_imm_in(id_use_imm_in), .id_alu_op_in(id_alu_op_in),
        .id_reg_write_in(id_reg_write_in), .id_mem_read_in(id_mem_read_in),
        .flush_in(flush_in),
        .ex_valid_out(nf_ex_valid_out), .ex_ready_in(ex_ready_in),
        .ex_operand1_out(nf_ex_operand1_out), .ex_operand2_out(nf_ex_operand2_out),
        .ex_alu_op_out(nf_ex_alu_op_out), .ex_rd_out(nf_ex_rd_out),
        .ex_reg_write_out(nf_ex_reg_write_out), .ex_mem_read_out(nf_ex_mem_read_out),
        .mem_rd_in(mem_rd_in), .mem_reg_write_in(mem_reg_write_in), .mem_result_in(mem_result_in),
        .wb_rd_in(wb_rd_in), .wb_reg_write_in(wb_reg_write_in), .wb_result_in(wb_result_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid_in = 1'b0; id_rs1_in = '0; id_rs2_in = '0; id_rd_in = '0;
        id_rs1_data_in = '0; id_rs2_data_in = '0; id_imm_in = '0; id_use_imm_in = 1'b0;
        id_alu_op_in = '0; id_reg_write_in = 1'b0; id_mem_read_in = 1'b0;
    endtask

    task automatic clear_fwd();
        mem_rd_in = '0; mem_reg_write_in = 1'b0; mem_result_in = '0;
        wb_rd_in = '0; wb_reg_write_in = 1'b0; wb_result_in = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                         input logic use_imm, input logic [3:0] op, input logic mr);
        id_valid_in = 1'b1; id_rs1_in = rs1; id_rs2_in = rs2; id_rd_in = rd;
        id_rs1_data_in = d1; id_rs2_data_in = d2; id_imm_in = imm; id_use_imm_in = use_imm;
        id_alu_op_in = op; id_reg_write_in = 1'b1; id_mem_read_in = mr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_in = 1'b0; ex_ready_in = 1'b1;
        idle(); clear_fwd();
        step(); step();
        checks++; if (ex_valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", ex_valid_out); end
        checks++; if (ex_operand1_out !== 64'd0 || ex_operand2_out !== 64'd0) begin failures++; $display("FAIL rst_operands got=%0h/%0h exp=0/0", ex_operand1_out, ex_operand2_out); end
        checks++; if (ex_alu_op_out !== 4'd0 || ex_rd_out !== 5'd0) begin failures++; $display("FAIL rst_ctrl got=%0h/%0h exp=0/0", ex_alu_op_out, ex_rd_out); end
        rst_n = 1'b1;
        issue(5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'd0, 1'b0, 4'd0, 1'b0);
        #1;
        checks++; if (id_ready_out !== 1'b0) begin failures++; $display("FAIL rst_release_ready got=%0h exp=0", id_ready_out); end
        step();
        checks++; if (ex_valid_out !== 1'b0) begin failures++; $display("FAIL rst_release_capture got=%0h exp=0", ex_valid_out); end
        idle();
    endtask

    task automatic test_add();
        ex_ready_in = 1'b1;
        issue(5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'd0, 1'b0, 4'b0000, 1'b0);
        #1;
        checks++; if (id_ready_out !== 1'b1) begin failures++; $display("FAIL add_ready got=%0h exp=1", id_ready_out); end
        step();
        idle();
        checks++; if (ex_valid_out !== 1'b1) begin failures++; $display("FAIL add_valid got=%0h exp=1", ex_valid_out); end
        checks++; if (ex_operand1_out !== 64'd5 || ex_operand2_out !== 64'd7) begin failures++; $display("FAIL add_operands got=%0h/%0h exp=5/7", ex_operand1_out, ex_operand2_out); end
        checks++; if (ex_alu_op_out !== 4'b0000 || ex_rd_out !== 5'd3 || ex_reg_write_out !== 1'b1) begin failures++; $display("FAIL add_ctrl got op=%0h rd=%0h rw=%0h exp=0/3/1", ex_alu_op_out, ex_rd_out, ex_reg_write_out); end
        issue(5'd1, 5'd2, 5'd4, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 4'b0110, 1'b0);
        step();
        idle();
        checks++; if (ex_operand2_out !== 64'hFFFF_FFFF_FFFF_FFF0 || ex_alu_op_out !== 4'b0110) begin failures++; $display("FAIL imm_operand got=%0h op=%0h exp=fffffffffffffff0/6", ex_operand2_out, ex_alu_op_out); end
        step();
        checks++; if (ex_valid_out !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%0h exp=0", ex_valid_out); end
    endtask

    task automatic test_forward();
        ex_ready_in = 1'b1;
        issue(5'd4, 5'd0, 5'd6, 64'h99, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
        step();
        idle(); ex_ready_in = 1'b0;
        mem_rd_in = 5'd4; mem_reg_write_in = 1'b1; mem_result_in = 64'h10;
        wb_rd_in = 5'd4; wb_reg_write_in = 1'b1; wb_result_in = 64'h20;
        #1;
        checks++; if (ex_operand1_out !== 64'h10) begin failures++; $display("FAIL fwd_mem_priority got=%0h exp=10", ex_operand1_out); end
        checks++; if (nf_ex_operand1_out !== 64'h99) begin failures++; $display("FAIL nofwd_captured got=%0h exp=99", nf_ex_operand1_out); end
        mem_reg_write_in = 1'b0;
        #1;
        checks++; if (ex_operand1_out !== 64'h20) begin failures++; $display("FAIL fwd_wb got=%0h exp=20", ex_operand1_out); end
        step();
        clear_fwd();
        #1;
        checks++; if (nf_ex_operand1_out !== 64'h20 || ex_operand1_out !== 64'h20) begin failures++; $display("FAIL hold_refresh got=%0h/%0h exp=20/20", ex_operand1_out, nf_ex_operand1_out); end
        ex_ready_in = 1'b1;
        issue(5'd8, 5'd0, 5'd9, 64'h1, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
        wb_rd_in = 5'd8; wb_reg_write_in = 1'b1; wb_result_in = 64'h77;
        step();
        idle(); clear_fwd();
        #1;
        checks++; if (ex_operand1_out !== 64'h77 || nf_ex_operand1_out !== 64'h77) begin failures++; $display("FAIL capture_bypass got=%0h/%0h exp=77/77", ex_operand1_out, nf_ex_operand1_out); end
        step();
    endtask

    task automatic test_load_use();
        ex_ready_in = 1'b1;
        issue(5'd1, 5'd0, 5'd5, 64'h100, 64'd0, 64'h8, 1'b1, 4'd0, 1'b1);
        step();
        issue(5'd1, 5'd5, 5'd11, 64'h1, 64'h2, 64'h4, 1'b1, 4'd0, 1'b0);
        #1;
        checks++; if (id_ready_out !== 1'b1) begin failures++; $display("FAIL loaduse_imm_no_stall got=%0h exp=1", id_ready_out); end
        issue(5'd5, 5'd2, 5'd7, 64'hAA, 64'hBB, 64'd0, 1'b0, 4'd0, 1'b0);
        #1;
        checks++; if (id_ready_out !== 1'b0) begin failures++; $display("FAIL loaduse_stall got=%0h exp=0", id_ready_out); end
        step();
        checks++; if (ex_valid_out !== 1'b0) begin failures++; $display("FAIL loaduse_bubble got=%0h exp=0", ex_valid_out); end
        checks++; if (id_ready_out !== 1'b1) begin failures++; $display("FAIL loaduse_release got=%0h exp=1", id_ready_out); end
        step();
        idle();
        checks++; if (ex_valid_out !== 1'b1 || ex_rd_out !== 5'd7 || ex_operand1_out !== 64'hAA) begin failures++; $display("FAIL loaduse_accept got v=%0h rd=%0h op1=%0h exp=1/7/aa", ex_valid_out, ex_rd_out, ex_operand1_out); end
        step();
    endtask

    task automatic test_stall();
        ex_ready_in = 1'b1;
        issue(5'd1, 5'd9, 5'd10, 64'h11, 64'h22, 64'd0, 1'b0, 4'b0011, 1'b0);
        step();
        ex_ready_in = 1'b0;
        issue(5'd2, 5'd3, 5'd12, 64'h33, 64'h44, 64'd0, 1'b0, 4'b0001, 1'b0);
        #1;
        checks++; if (id_ready_out !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0h exp=0", id_ready_out); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ex_valid_out !== 1'b1 || ex_operand1_out !== 64'h11 || ex_operand2_out !== 64'h22 ||
                ex_rd_out !== 5'd10 || ex_alu_op_out !== 4'b0011) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%0h op1=%0h op2=%0h rd=%0h op=%0h exp=1/11/22/a/3",
                         i, ex_valid_out, ex_operand1_out, ex_operand2_out, ex_rd_out, ex_alu_op_out);
            end
        end
        wb_rd_in = 5'd9; wb_reg_write_in = 1'b1; wb_result_in = 64'h55;
        step();
        clear_fwd();
        #1;
        checks++; if (ex_operand2_out !== 64'h55 || nf_ex_operand2_out !== 64'h55) begin failures++; $display("FAIL stall_refresh_rs2 got=%0h/%0h exp=55/55", ex_operand2_out, nf_ex_operand2_out); end
        ex_ready_in = 1'b1;
        step();
        checks++; if (ex_rd_out !== 5'd12 || ex_operand1_out !== 64'h33 || ex_valid_out !== 1'b1) begin failures++; $display("FAIL stall_next got rd=%0h op1=%0h v=%0h exp=c/33/1", ex_rd_out, ex_operand1_out, ex_valid_out); end
    endtask

    task automatic test_flush();
        ex_ready_in = 1'b0;
        issue(5'd1, 5'd2, 5'd13, 64'h1, 64'h2, 64'd0, 1'b0, 4'd0, 1'b0);
        flush_in = 1'b1;
        #1;
        checks++; if (id_ready_out !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0h exp=0", id_ready_out); end
        step();
        flush_in = 1'b0; idle();
        checks++; if (ex_valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", ex_valid_out); end
        ex_ready_in = 1'b1;
        issue(5'd0, 5'd0, 5'd1, 64'd0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
        mem_rd_in = 5'd0; mem_reg_write_in = 1'b1; mem_result_in = 64'hFF;
        wb_rd_in = 5'd0; wb_reg_write_in = 1'b1; wb_result_in = 64'hEE;
        step();
        idle(); ex_ready_in = 1'b0;
        checks++; if (ex_operand1_out !== 64'd0 || ex_operand2_out !== 64'd0) begin failures++; $display("FAIL x0_no_forward got=%0h/%0h exp=0/0", ex_operand1_out, ex_operand2_out); end
        step();
        clear_fwd();
        #1;
        checks++; if (ex_operand1_out !== 64'd0 || nf_ex_operand1_out !== 64'd0) begin failures++; $display("FAIL x0_no_refresh got=%0h/%0h exp=0/0", ex_operand1_out, nf_ex_operand1_out); end
    endtask

    task automatic test_async_reset();
        ex_ready_in = 1'b1;
        step();
        issue(5'd1, 5'd2, 5'd14, 64'h123, 64'h456, 64'd0, 1'b0, 4'b0101, 1'b0);
        step();
        ex_ready_in = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid_out !== 1'b0 || ex_operand1_out !== 64'd0 || ex_operand2_out !== 64'd0 || ex_alu_op_out !== 4'd0) begin failures++; $display("FAIL async_reset got v=%0h op1=%0h op2=%0h op=%0h exp=0/0/0/0", ex_valid_out, ex_operand1_out, ex_operand2_out, ex_alu_op_out); end
        idle();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_load_use();
        test_stall();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
